// File: rtl/hrm_mailbox.sv
// hrm_mailbox: parametrised first-word-fall-through mailbox queue used as the
// HRM-CPU INBOX / OUTBOX.
//
// Parameters: DATA_W (word width), LGFLEN (log2 depth), AF_THRESH, AE_THRESH.
// Optional build macro: HRM_MAILBOX_DUMP_EN enables the head-relative dump
// read port; when undefined the dump outputs are tied to 0.
//
// Ports:
//   clk              clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_wr / i_data    push request and data
//   i_rd             pop request
//   o_data           head entry (0 when empty)
//   o_empty_n        queue holds at least one entry
//   o_full           queue holds 2**LGFLEN entries
//   o_level          occupancy 0..2**LGFLEN
//   o_almost_full    level >= AF_THRESH
//   o_almost_empty   level <= AE_THRESH
//   i_flush          synchronous discard of all entries
//   o_overflow       sticky: push refused because full with no pop
//   o_underflow      sticky: pop requested while empty
//   i_clr_err        synchronous clear of both sticky flags (set wins)
//   i_dmp_pos        dump offset from head
//   o_dmp_data       entry at head+i_dmp_pos (0 when invalid)
//   o_dmp_valid      i_dmp_pos < level
module hrm_mailbox #(
  parameter int DATA_W    = 8,
  parameter int LGFLEN    = 5,
  parameter int AF_THRESH = 2**LGFLEN-2,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty_n,
  output logic              o_full,
  output logic [LGFLEN:0]   o_level,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  input  logic              i_flush,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_clr_err,
  input  logic [LGFLEN-1:0] i_dmp_pos,
  output logic [DATA_W-1:0] o_dmp_data,
  output logic              o_dmp_valid
);

  localparam int             DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0] LP_DEPTH = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0] LP_AF    = AF_THRESH[LGFLEN:0];
  localparam logic [LGFLEN:0] LP_AE    = AE_THRESH[LGFLEN:0];
  localparam logic [LGFLEN:0] LP_ONE   = {{LGFLEN{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [LGFLEN-1:0] r_wr_ptr, r_rd_ptr;
  logic [LGFLEN:0]   r_level;
  logic              r_ovf, r_udf;

  logic w_full, w_empty, w_push, w_pop, w_ovf, w_udf;

  assign w_full  = (r_level == LP_DEPTH);
  assign w_empty = (r_level == '0);

  // A pop in the same cycle frees a slot, so a push into a full queue is
  // still accepted. A pop from an empty queue is never bypassed by a push.
  assign w_push = i_wr && (!w_full || i_rd) && !i_flush;
  assign w_pop  = i_rd && !w_empty && !i_flush;
  assign w_ovf  = i_wr && w_full && !i_rd && !i_flush;
  assign w_udf  = i_rd && w_empty && !i_flush;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + LP_ONE;
      else if (w_pop && !w_push) r_level <= r_level - LP_ONE;
    end
  end

  // Sticky error flags: a new error in the clearing cycle wins.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !i_clr_err) || w_ovf;
      r_udf <= (r_udf && !i_clr_err) || w_udf;
    end
  end

  // Storage carries no reset; content is qualified by r_level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data         = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty_n      = !w_empty;
  assign o_full         = w_full;
  assign o_level        = r_level;
  assign o_almost_full  = (r_level >= LP_AF);
  assign o_almost_empty = (r_level <= LP_AE);
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;

`ifdef HRM_MAILBOX_DUMP_EN
  logic [LGFLEN-1:0] w_dmp_idx;
  logic              w_dmp_valid;

  // Offset is head-relative and wraps with the pointers.
  assign w_dmp_idx   = r_rd_ptr + i_dmp_pos;
  assign w_dmp_valid = ({1'b0, i_dmp_pos} < r_level);
  assign o_dmp_valid = w_dmp_valid;
  assign o_dmp_data  = w_dmp_valid ? r_mem[w_dmp_idx] : '0;
`else
  logic w_unused_dmp;

  assign w_unused_dmp = ^i_dmp_pos;
  assign o_dmp_valid  = 1'b0;
  assign o_dmp_data   = '0;
`endif

endmodule

// File: tb/tb_hrm_mailbox.sv
module tb_hrm_mailbox;

  localparam int DW = 8;
  localparam int LG = 5;
  localparam int DEPTH = 1 << LG;
  localparam int AF = DEPTH - 2;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_wr = 1'b0, i_rd = 1'b0, i_flush = 1'b0, i_clr_err = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic [LG-1:0] i_dmp_pos = '0;
  logic [DW-1:0] o_data, o_dmp_data;
  logic          o_empty_n, o_full, o_almost_full, o_almost_empty;
  logic          o_overflow, o_underflow, o_dmp_valid;
  logic [LG:0]   o_level;

  hrm_mailbox #(.DATA_W(DW), .LGFLEN(LG), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .i_rst(i_rst), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
    .o_data(o_data), .o_empty_n(o_empty_n), .o_full(o_full), .o_level(o_level),
    .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
    .i_flush(i_flush), .o_overflow(o_overflow), .o_underflow(o_underflow),
    .i_clr_err(i_clr_err), .i_dmp_pos(i_dmp_pos), .o_dmp_data(o_dmp_data),
    .o_dmp_valid(o_dmp_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of words plus two sticky bits.
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0, m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applies the queue rules for one clock edge using the inputs present at it.
  task automatic model_edge();
    bit full, empty;
    if (i_flush) begin
      q.delete();
      if (i_clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (i_clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (i_wr && full && !i_rd) m_ovf = 1'b1;
      if (i_rd && empty) m_udf = 1'b1;
      if (i_rd && !empty) void'(q.pop_front());
      if (i_wr && (!full || i_rd)) q.push_back(i_data);
    end
  endtask

  task automatic check_all(input string tag);
    int lvl;
    logic [DW-1:0] exp_dd;
    logic exp_dv;
    lvl = q.size();
    chk({tag, ".level"}, 32'(o_level), 32'(lvl));
    chk({tag, ".empty_n"}, 32'(o_empty_n), 32'(lvl != 0));
    chk({tag, ".full"}, 32'(o_full), 32'(lvl == DEPTH));
    chk({tag, ".af"}, 32'(o_almost_full), 32'(lvl >= AF));
    chk({tag, ".ae"}, 32'(o_almost_empty), 32'(lvl <= AE));
    chk({tag, ".data"}, 32'(o_data), 32'((lvl != 0) ? q[0] : 8'h00));
    chk({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(o_underflow), 32'(m_udf));
`ifdef HRM_MAILBOX_DUMP_EN
    exp_dv = (int'(i_dmp_pos) < lvl);
    exp_dd = exp_dv ? q[int'(i_dmp_pos)] : 8'h00;
`else
    exp_dv = 1'b0;
    exp_dd = 8'h00;
`endif
    chk({tag, ".dmp_v"}, 32'(o_dmp_valid), 32'(exp_dv));
    chk({tag, ".dmp_d"}, 32'(o_dmp_data), 32'(exp_dd));
  endtask

  // One clock: drive inputs, take the edge in model and DUT, check after it.
  task automatic cyc(input string tag, input logic wr, input logic [DW-1:0] d,
                     input logic rd, input logic fl, input logic clr);
    i_wr = wr; i_data = d; i_rd = rd; i_flush = fl; i_clr_err = clr;
    @(posedge clk);
    model_edge();
    #1;
    i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic set_pos(input logic [LG-1:0] p);
    i_dmp_pos = p;
    #1;
  endtask

  initial begin
    // Reset state.
    #2;
    check_all("rst_hold");
    chk("rst_ae", 32'(o_almost_empty), 32'd1);
    @(posedge clk); #1;
    i_rst = 1'b0;
    check_all("rst_rel");

    // Three pushes, head visible after the first edge.
    cyc("p11", 1, 8'h11, 0, 0, 0);
    chk("head_11", 32'(o_data), 32'h11);
    chk("ae_l1", 32'(o_almost_empty), 32'd1);
    cyc("p22", 1, 8'h22, 0, 0, 0);
    chk("ae_l2", 32'(o_almost_empty), 32'd0);
    cyc("p33", 1, 8'h33, 0, 0, 0);
    chk("lvl3", 32'(o_level), 32'd3);

    // Fill to depth with 0..31, then one refused push.
    cyc("fl0", 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc("fill", 1, 8'(i), 0, 0, 0);
      if (i + 1 == AF) chk("af_at30", 32'(o_almost_full), 32'd1);
      if (i + 1 == AF - 1) chk("af_at29", 32'(o_almost_full), 32'd0);
    end
    chk("full32", 32'(o_full), 32'd1);
    cyc("ovf", 1, 8'hEE, 0, 0, 0);
    chk("ovf_lvl", 32'(o_level), 32'd32);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    chk("ovf_head", 32'(o_data), 32'd0);

    // Push+pop while full.
    cyc("clr1", 0, 8'h00, 0, 0, 1);
    chk("ovf_clr", 32'(o_overflow), 32'd0);
    cyc("fullrw", 1, 8'hAA, 1, 0, 0);
    chk("frw_lvl", 32'(o_level), 32'd32);
    chk("frw_head", 32'(o_data), 32'd1);
    chk("frw_ovf", 32'(o_overflow), 32'd0);
    set_pos(5'd31);
    check_all("dmp31");

    // Underflow and its clearing.
    set_pos(5'd0);
    cyc("fl1", 0, 8'h00, 0, 1, 0);
    cyc("udf", 0, 8'h00, 1, 0, 0);
    chk("udf_set", 32'(o_underflow), 32'd1);
    chk("udf_lvl", 32'(o_level), 32'd0);
    cyc("udf_clr", 0, 8'h00, 0, 0, 1);
    chk("udf_clr0", 32'(o_underflow), 32'd0);
    cyc("udf_win", 0, 8'h00, 1, 0, 1);
    chk("udf_win1", 32'(o_underflow), 32'd1);
    cyc("clr2", 0, 8'h00, 0, 0, 1);
    // Push+pop on empty: push taken, pop refused.
    cyc("erw", 1, 8'h5A, 1, 0, 0);
    chk("erw_lvl", 32'(o_level), 32'd1);
    chk("erw_udf", 32'(o_underflow), 32'd1);
    cyc("clr3", 0, 8'h00, 1, 0, 1);

    // Wrap-around with small level.
    for (int i = 0; i < 40; i++) begin
      cyc("wrap", 1, 8'($urandom), q.size() >= 3, 0, 0);
      if (o_level > 4) chk("wrap_le4", 32'(o_level), 32'd4);
    end
    while (q.size() != 0) cyc("drain", 0, 8'h00, 1, 0, 0);
    cyc("wa0", 1, 8'hA0, 0, 0, 0);
    cyc("wa1", 1, 8'hA1, 0, 0, 0);
    cyc("w55", 1, 8'h55, 0, 0, 0);
    set_pos(5'd2);
    check_all("dmp2");
`ifdef HRM_MAILBOX_DUMP_EN
    chk("dmp2_55", 32'(o_dmp_data), 32'h55);
    chk("dmp2_v", 32'(o_dmp_valid), 32'd1);
`endif
    set_pos(5'd5);
    check_all("dmp5");
    chk("dmp5_v", 32'(o_dmp_valid), 32'd0);
    for (int i = 0; i < 3; i++) cyc("wpop", 0, 8'h00, 1, 0, 0);
    chk("wpop_e", 32'(o_empty_n), 32'd0);

    // Flush at level 7 together with a push.
    for (int i = 0; i < 7; i++) cyc("l7", 1, 8'(8'h70 + i), 0, 0, 0);
    chk("l7_lvl", 32'(o_level), 32'd7);
    cyc("flwr", 1, 8'hBB, 0, 1, 0);
    chk("fl_lvl", 32'(o_level), 32'd0);
    chk("fl_en", 32'(o_empty_n), 32'd0);

    // Async reset mid-fill, checked before any clock edge.
    for (int i = 0; i < 5; i++) cyc("mf", 1, 8'($urandom), 0, 0, 0);
    i_rst = 1'b1;
    #1;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    chk("arst_en", 32'(o_empty_n), 32'd0);
    chk("arst_lvl", 32'(o_level), 32'd0);
    check_all("arst");
    @(posedge clk); #1;
    i_rst = 1'b0;
    check_all("arst_rel");

    // Randomized traffic, alternating fill- and drain-biased phases.
    for (int i = 0; i < 600; i++) begin
      bit fillp;
      fillp = ((i / 75) % 2) == 0;
      i_dmp_pos = LG'($urandom_range(0, DEPTH - 1));
      cyc("rnd",
          fillp ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
          8'($urandom),
          fillp ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 63) == 0,
          $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
